trdb_qual_ctrl: RTL and testbench

Trace-window sequencer placed between trdb_filter and the packet emitter of the trace encoder. It consumes the per-instruction nc_qualified result from the filter and opens and closes trace windows. It applies stop-hysteresis, an instruction-count limit and one-shot mode, and it pulses start/stop so the emitter can send sync/final packets. All outputs are registered, with 1-cycle latency from the retired instruction.

---
 rtl/trdb_qual_ctrl.sv | 95 +++++++++
 tb/tb_trdb_qual_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/trdb_qual_ctrl.sv
// trdb_qual_ctrl: trace-window sequencer with stop hysteresis, instruction limit and one-shot mode
module trdb_qual_ctrl #(
  parameter int CNT_W = 16,
  parameter int DLY_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             trace_enable_i,
  input  logic             oneshot_i,
  input  logic [DLY_W-1:0] stop_delay_i,
  input  logic [CNT_W-1:0] limit_i,
  input  logic             valid_i,
  input  logic             nc_qualified_i,
  output logic             qualified_o,
  output logic             start_o,
  output logic             stop_o,
  output logic             done_o,
  output logic [CNT_W-1:0] win_cnt_o
);
  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_TRACING, S_HOLD, S_DONE} state_t;
  state_t           r_state;
  logic [DLY_W-1:0] r_hold;
  logic [CNT_W-1:0] r_cnt;
  logic             r_qual;
  logic             r_start;
  logic             r_stop;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_lim_hit;
  logic             w_drop;
  state_t           w_close_st;
  // Saturating count of the next traced instruction and the close decisions derived from it
  always_comb begin
    w_cnt_inc  = &r_cnt ? r_cnt : r_cnt + 1'b1;
    w_lim_hit  = (limit_i != '0) && (w_cnt_inc >= limit_i);
    w_drop     = !nc_qualified_i && ((r_state == S_TRACING) ? (stop_delay_i == '0) : (r_hold == '0));
    w_close_st = oneshot_i ? S_DONE : S_ARMED;
  end
  // Window sequencer: disable beats the limit, which beats the qualification verdict
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_cnt   <= '0;
      r_qual  <= 1'b0;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
    end else begin
      r_qual  <= 1'b0;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      case (r_state)
        S_IDLE: if (trace_enable_i) r_state <= S_ARMED;
        S_ARMED: begin
          if (!trace_enable_i) r_state <= S_IDLE;
          else if (valid_i && nc_qualified_i) begin
            r_qual  <= 1'b1;
            r_start <= 1'b1;
            r_cnt   <= CNT_W'(1);
            r_stop  <= (limit_i == CNT_W'(1));
            r_state <= (limit_i == CNT_W'(1)) ? w_close_st : S_TRACING;
          end
        end
        S_TRACING, S_HOLD: begin
          if (!trace_enable_i) begin
            r_stop  <= 1'b1;
            r_state <= S_IDLE;
          end else if (valid_i) begin
            if (w_drop) begin
              r_stop  <= 1'b1;
              r_state <= w_close_st;
            end else begin
              r_qual <= 1'b1;
              r_cnt  <= w_cnt_inc;
              if (w_lim_hit) begin
                r_stop  <= 1'b1;
                r_state <= w_close_st;
              end else if (nc_qualified_i) r_state <= S_TRACING;
              else if (r_state == S_TRACING) begin
                r_hold  <= stop_delay_i - 1'b1;
                r_state <= S_HOLD;
              end else r_hold <= r_hold - 1'b1;
            end
          end
        end
        S_DONE: if (!trace_enable_i) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign qualified_o = r_qual;
  assign start_o     = r_start;
  assign stop_o      = r_stop;
  assign done_o      = (r_state == S_DONE);
  assign win_cnt_o   = r_cnt;
endmodule

// File: tb/tb_trdb_qual_ctrl.sv
// tb_trdb_qual_ctrl: directed vector table plus randomized run against a window-level reference model
module tb_trdb_qual_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, en, os, v, q;
  logic [7:0]  dly;
  logic [15:0] lim;
  logic        qual_o, start_o, stop_o, done_o;
  logic [15:0] cnt_o;
  int checks = 0;
  int failures = 0;

  trdb_qual_ctrl #(.CNT_W(16), .DLY_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .trace_enable_i(en), .oneshot_i(os),
    .stop_delay_i(dly), .limit_i(lim), .valid_i(v), .nc_qualified_i(q),
    .qualified_o(qual_o), .start_o(start_o), .stop_o(stop_o),
    .done_o(done_o), .win_cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst_n, en, os; logic [7:0] dly; logic [15:0] lim; logic v, q;
    logic eq, es, ep, ed; logic [15:0] ec;
  } vec_t;
  vec_t tbl[$];

  // Reference model: a window is open or not, an armed flag, a finished flag,
  // and a budget of unqualified instructions still traced (-1 = not yet loaded).
  bit m_open, m_armed, m_done;
  int m_budget, m_cnt;
  logic m_q, m_s, m_p;

  task automatic m_close(input logic ones);
    m_open = 0;
    m_p = 1;
    if (ones) m_done = 1; else m_armed = 1;
  endtask

  task automatic m_step(input logic r, e, o, input logic [7:0] d, input logic [15:0] l, input logic vv, qq);
    bit traced;
    m_q = 0; m_s = 0; m_p = 0; traced = 0;
    if (!r) begin
      m_open = 0; m_armed = 0; m_done = 0; m_budget = -1; m_cnt = 0;
    end else if (!e) begin
      if (m_open) m_p = 1;
      m_open = 0; m_armed = 0; m_done = 0;
    end else if (m_done) begin
    end else if (!m_armed && !m_open) m_armed = 1;
    else if (vv) begin
      if (!m_open) begin
        if (qq) begin
          traced = 1; m_s = 1; m_cnt = 0; m_open = 1; m_armed = 0; m_budget = -1;
        end
      end else if (qq) begin
        traced = 1; m_budget = -1;
      end else begin
        if (m_budget < 0) m_budget = int'(d);
        if (m_budget == 0) m_close(o);
        else begin
          m_budget--; traced = 1;
        end
      end
      if (traced) begin
        m_q = 1;
        m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
        if (l != 0 && m_cnt >= int'(l)) m_close(o);
      end
    end
  endtask

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got q/s/p/d=%b%b%b%b cnt=%0d, want q/s/p/d=%b%b%b%b cnt=%0d",
               name, act[19], act[18], act[17], act[16], act[15:0],
               exp[19], exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  task automatic add(input logic r, e, o, input int d, l, input logic vv, qq, eq, es, ep, ed, input int ec);
    vec_t t;
    t.rst_n = r; t.en = e; t.os = o; t.dly = 8'(d); t.lim = 16'(l); t.v = vv; t.q = qq;
    t.eq = eq; t.es = es; t.ep = ep; t.ed = ed; t.ec = 16'(ec);
    tbl.push_back(t);
  endtask

  initial begin
    //  rst en os dly lim v q | q s p d cnt
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 1,  1, 1, 0, 0, 1);
    add(1, 1, 0, 0, 0, 1, 1,  1, 0, 0, 0, 2);
    add(1, 1, 0, 0, 0, 1, 1,  1, 0, 0, 0, 3);
    add(1, 1, 0, 0, 0, 1, 0,  0, 0, 1, 0, 3);
    add(1, 1, 0, 2, 0, 1, 1,  1, 1, 0, 0, 1);
    add(1, 1, 0, 2, 0, 1, 0,  1, 0, 0, 0, 2);
    add(1, 1, 0, 2, 0, 0, 0,  0, 0, 0, 0, 2);
    add(1, 1, 0, 2, 0, 1, 0,  1, 0, 0, 0, 3);
    add(1, 1, 0, 2, 0, 1, 0,  0, 0, 1, 0, 3);
    add(1, 1, 0, 2, 0, 1, 1,  1, 1, 0, 0, 1);
    add(1, 1, 0, 2, 0, 1, 0,  1, 0, 0, 0, 2);
    add(1, 1, 0, 2, 0, 1, 1,  1, 0, 0, 0, 3);
    add(1, 1, 0, 2, 0, 1, 0,  1, 0, 0, 0, 4);
    add(1, 1, 0, 2, 0, 1, 0,  1, 0, 0, 0, 5);
    add(1, 1, 0, 2, 0, 1, 0,  0, 0, 1, 0, 5);
    add(1, 1, 0, 0, 3, 1, 1,  1, 1, 0, 0, 1);
    add(1, 1, 0, 0, 3, 1, 1,  1, 0, 0, 0, 2);
    add(1, 1, 0, 0, 3, 1, 1,  1, 0, 1, 0, 3);
    add(1, 1, 0, 0, 3, 1, 1,  1, 1, 0, 0, 1);
    add(1, 1, 0, 0, 3, 1, 1,  1, 0, 0, 0, 2);
    add(1, 1, 0, 0, 1, 1, 1,  1, 0, 1, 0, 3);
    add(1, 1, 0, 0, 1, 1, 1,  1, 1, 1, 0, 1);
    add(1, 1, 1, 0, 0, 1, 1,  1, 1, 0, 0, 1);
    add(1, 1, 1, 0, 0, 1, 0,  0, 0, 1, 1, 1);
    add(1, 1, 1, 0, 0, 1, 1,  0, 0, 0, 1, 1);
    add(1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    add(1, 1, 1, 0, 0, 1, 1,  0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 1, 1,  1, 1, 0, 0, 1);
    add(1, 1, 0, 5, 0, 1, 0,  1, 0, 0, 0, 2);
    add(1, 0, 0, 5, 0, 1, 1,  0, 0, 1, 0, 2);
    add(1, 1, 0, 5, 0, 1, 1,  0, 0, 0, 0, 2);
    add(1, 1, 0, 0, 0, 1, 1,  1, 1, 0, 0, 1);
    add(1, 1, 0, 0, 0, 1, 1,  1, 0, 0, 0, 2);
    add(0, 1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 1,  1, 1, 0, 0, 1);

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; en = tbl[i].en; os = tbl[i].os;
      dly = tbl[i].dly; lim = tbl[i].lim; v = tbl[i].v; q = tbl[i].q;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), {qual_o, start_o, stop_o, done_o, cnt_o},
            {tbl[i].eq, tbl[i].es, tbl[i].ep, tbl[i].ed, tbl[i].ec});
    end

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] lims[7];
      lims = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8};
      rst_n = (i == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
      en    = ($urandom_range(0, 19) != 0);
      os    = ($urandom_range(0, 4) == 0);
      dly   = 8'($urandom_range(0, 3));
      lim   = lims[$urandom_range(0, 6)];
      v     = ($urandom_range(0, 9) < 7);
      q     = ($urandom_range(0, 9) < 6);
      m_step(rst_n, en, os, dly, lim, v, q);
      @(posedge clk); #1;
      check($sformatf("rnd%0d", i), {qual_o, start_o, stop_o, done_o, cnt_o},
            {m_q, m_s, m_p, logic'(m_done), 16'(m_cnt)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
